// File: rtl/table_fsm_if.sv
// Control, table-programming and status bundle for table_fsm.
interface table_fsm_if #(
   parameter int unsigned STATE_W = 3,
   parameter int unsigned IN_W    = 1,
   parameter int unsigned DWELL_W = 8
);
   logic               en;
   logic               sync_clr;
   logic [IN_W-1:0]    x;
   logic               tbl_we;
   logic [STATE_W-1:0] tbl_state;
   logic [IN_W-1:0]    tbl_in;
   logic [STATE_W-1:0] tbl_next;
   logic               tbl_err;
   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] prev_state;
   logic               state_changed;
   logic [DWELL_W-1:0] dwell;
   logic               illegal;

   modport master (
      output en, sync_clr, x, tbl_we, tbl_state, tbl_in, tbl_next,
      input  tbl_err, state, prev_state, state_changed, dwell, illegal
   );

   modport slave (
      input  en, sync_clr, x, tbl_we, tbl_state, tbl_in, tbl_next,
      output tbl_err, state, prev_state, state_changed, dwell, illegal
   );
endinterface

// File: rtl/table_fsm.sv
// Table-driven Moore FSM: run-time programmable transitions, change strobe,
// previous-state tracking, saturating dwell counter and illegal-state recovery.
module table_fsm #(
   parameter int unsigned NUM_STATES  = 5,
   parameter int unsigned STATE_W     = 3,
   parameter int unsigned IN_W        = 1,
   parameter int unsigned RESET_STATE = 0,
   parameter int unsigned DWELL_W     = 8
) (
   input logic        clk,
   input logic        reset,
   table_fsm_if.slave bus
);
   localparam int unsigned      NUM_IN  = 2 ** IN_W;
   localparam logic [STATE_W:0] NUM_S   = (STATE_W + 1)'(NUM_STATES);
   localparam logic [STATE_W-1:0] RST_S = STATE_W'(RESET_STATE);

   logic [STATE_W-1:0] tbl [NUM_STATES][NUM_IN];

   logic [STATE_W-1:0] state_q, state_d;
   logic [STATE_W-1:0] prev_q, prev_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               changed_q, changed_d;
   logic               illegal_q, illegal_d;
   logic               err_q, err_d;
   logic [STATE_W-1:0] step_s;
   logic               wr_ok;
   logic               cur_legal;

   // Widened compare so NUM_STATES == 2**STATE_W does not wrap to zero.
   function automatic logic in_range(input logic [STATE_W-1:0] v);
      return {1'b0, v} < NUM_S;
   endfunction

   assign cur_legal = in_range(state_q);
   assign wr_ok     = bus.tbl_we && in_range(bus.tbl_state) && in_range(bus.tbl_next);

   // Transition lookup; an illegal current state never indexes the table.
   always_comb begin
      step_s = state_q;
      for (int s = 0; s < int'(NUM_STATES); s++) begin
         for (int i = 0; i < int'(NUM_IN); i++) begin
            if (state_q == STATE_W'(s) && bus.x == IN_W'(i)) step_s = tbl[s][i];
         end
      end
   end

   // Table storage: defaults to a ring on reset, written independently of stepping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < int'(NUM_STATES); s++) begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
               tbl[s][i] <= STATE_W'((s + 1) % int'(NUM_STATES));
            end
         end
      end else if (wr_ok) begin
         for (int s = 0; s < int'(NUM_STATES); s++) begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
               if (bus.tbl_state == STATE_W'(s) && bus.tbl_in == IN_W'(i))
                  tbl[s][i] <= bus.tbl_next;
            end
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= RST_S;
         prev_q    <= RST_S;
         dwell_q   <= '0;
         changed_q <= 1'b0;
         illegal_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         prev_q    <= prev_d;
         dwell_q   <= dwell_d;
         changed_q <= changed_d;
         illegal_q <= illegal_d;
         err_q     <= err_d;
      end
   end

   // Next state and status: sync_clr > illegal recovery > step > hold.
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      prev_d    = prev_q;
      dwell_d   = dwell_q;
      changed_d = 1'b0;
      err_d     = bus.tbl_we && !wr_ok;

      if (bus.sync_clr) begin
         state_d   = RST_S;
         illegal_d = 1'b0;
      end else if (!cur_legal) begin
         state_d   = RST_S;
         illegal_d = 1'b1;
      end else if (bus.en) begin
         state_d = step_s;
      end

      if (state_d != state_q) begin
         prev_d    = state_q;
         changed_d = 1'b1;
         dwell_d   = '0;
      end else if (bus.sync_clr) begin
         dwell_d = '0;
      end else if (dwell_q != '1) begin
         dwell_d = dwell_q + DWELL_W'(1);
      end
   end

   assign bus.state         = state_q;
   assign bus.prev_state    = prev_q;
   assign bus.dwell         = dwell_q;
   assign bus.state_changed = changed_q;
   assign bus.illegal       = illegal_q;
   assign bus.tbl_err       = err_q;
endmodule

// File: tb/tb_table_fsm.sv
// Directed self-checking bench for table_fsm (5 states, 1-bit input, 8-bit dwell).
module tb_table_fsm;
   logic clk;
   logic reset;
   int   n_total;
   int   n_pass;
   logic saw_change;

   table_fsm_if #(.STATE_W(3), .IN_W(1), .DWELL_W(8)) bus ();

   table_fsm #(
      .NUM_STATES(5), .STATE_W(3), .IN_W(1), .RESET_STATE(0), .DWELL_W(8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] s, input logic i, input logic [2:0] n);
      bus.tbl_we    = 1'b1;
      bus.tbl_state = s;
      bus.tbl_in    = i;
      bus.tbl_next  = n;
      step();
      bus.tbl_we    = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_total = 0;
      n_pass  = 0;
      reset   = 1'b1;
      bus.en = 1'b0; bus.sync_clr = 1'b0; bus.x = 1'b0;
      bus.tbl_we = 1'b0; bus.tbl_state = '0; bus.tbl_in = 1'b0; bus.tbl_next = '0;
      #12;
      chk("rst_state", bus.state, 0);
      chk("rst_prev", bus.prev_state, 0);
      chk("rst_changed", bus.state_changed, 0);
      chk("rst_dwell", bus.dwell, 0);
      chk("rst_illegal", bus.illegal, 0);
      chk("rst_tbl_err", bus.tbl_err, 0);
      reset = 1'b0;

      // Default ring
      bus.en = 1'b1; bus.x = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("ring_state", bus.state, (k + 1) % 5);
         chk("ring_prev", bus.prev_state, k % 5);
         chk("ring_changed", bus.state_changed, 1);
         chk("ring_dwell", bus.dwell, 0);
      end
      bus.en = 1'b0;

      // Programmed entries
      wr(3'd0, 1'b0, 3'd1); chk("wr00_err", bus.tbl_err, 0);
      wr(3'd0, 1'b1, 3'd2); chk("wr01_err", bus.tbl_err, 0);
      wr(3'd1, 1'b1, 3'd4); chk("wr11_err", bus.tbl_err, 0);
      wr(3'd4, 1'b0, 3'd1); chk("wr40_err", bus.tbl_err, 0);
      wr(3'd2, 1'b0, 3'd0); chk("wr20_err", bus.tbl_err, 0);
      bus.en = 1'b1; bus.x = 1'b0;
      step(); chk("p_1to2", bus.state, 2);
      step(); chk("p_2to0", bus.state, 0);
      bus.x = 1'b1;
      step(); chk("p_0to2", bus.state, 2);
      step(); chk("p_2to3", bus.state, 3);
      chk("p_2to3_prev", bus.prev_state, 2);
      bus.x = 1'b0;
      step(); chk("p_3to4", bus.state, 4);
      step(); chk("p_4to1", bus.state, 1);
      bus.en = 1'b0;

      // Rejected writes
      wr(3'd5, 1'b0, 3'd2); chk("rej_row_err", bus.tbl_err, 1);
      step();               chk("rej_err_pulse", bus.tbl_err, 0);
      wr(3'd0, 1'b0, 3'd6); chk("rej_next_err", bus.tbl_err, 1);
      step();               chk("rej_err_pulse2", bus.tbl_err, 0);
      chk("rej_state_hold", bus.state, 1);

      // Write coincident with step uses the old entry
      bus.en = 1'b1; bus.x = 1'b0;
      step(); chk("c_1to2", bus.state, 2);
      step(); chk("c_2to0", bus.state, 0);
      bus.tbl_we = 1'b1; bus.tbl_state = 3'd0; bus.tbl_in = 1'b0; bus.tbl_next = 3'd3;
      step(); bus.tbl_we = 1'b0;
      chk("c_old_entry", bus.state, 1);
      chk("c_err", bus.tbl_err, 0);
      step(); chk("c_1to2b", bus.state, 2);
      step(); chk("c_2to0b", bus.state, 0);
      step(); chk("c_new_entry", bus.state, 3);

      // Self-loop and dwell saturation
      bus.en = 1'b0;
      wr(3'd2, 1'b0, 3'd2);
      bus.en = 1'b1; bus.x = 1'b0;
      step(); chk("d_3to4", bus.state, 4);
      step(); chk("d_4to1", bus.state, 1);
      step(); chk("d_1to2", bus.state, 2);
      chk("d_enter_changed", bus.state_changed, 1);
      chk("d_enter_dwell", bus.dwell, 0);
      saw_change = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         step();
         if (bus.state_changed) saw_change = 1'b1;
         if (k == 1) begin
            chk("d_dwell1", bus.dwell, 1);
            chk("d_prev_hold", bus.prev_state, 1);
         end
         if (k == 254) chk("d_dwell254", bus.dwell, 254);
         if (k == 255) chk("d_dwell255", bus.dwell, 255);
      end
      chk("d_no_change", saw_change, 0);
      chk("d_sat_dwell", bus.dwell, 255);
      chk("d_sat_state", bus.state, 2);
      bus.en = 1'b0;
      step();
      chk("d_hold_state", bus.state, 2);
      chk("d_hold_dwell", bus.dwell, 255);

      // Illegal state recovery
      force dut.state_q = 3'd7;
      #1;
      release dut.state_q;
      chk("i_forced", bus.state, 7);
      step();
      chk("i_state", bus.state, 0);
      chk("i_illegal", bus.illegal, 1);
      chk("i_prev", bus.prev_state, 7);
      chk("i_changed", bus.state_changed, 1);
      step();
      chk("i_sticky", bus.illegal, 1);
      chk("i_dwell", bus.dwell, 1);
      bus.sync_clr = 1'b1;
      bus.tbl_we = 1'b1; bus.tbl_state = 3'd3; bus.tbl_in = 1'b1; bus.tbl_next = 3'd0;
      step();
      bus.sync_clr = 1'b0; bus.tbl_we = 1'b0;
      chk("s_illegal", bus.illegal, 0);
      chk("s_state", bus.state, 0);
      chk("s_dwell", bus.dwell, 0);
      chk("s_changed", bus.state_changed, 0);
      chk("s_err", bus.tbl_err, 0);
      bus.en = 1'b1; bus.x = 1'b0;
      step(); chk("s_retained", bus.state, 3);
      bus.x = 1'b1;
      step(); chk("s_write_in_clr", bus.state, 0);

      // Asynchronous reset mid-sequence
      bus.x = 1'b0;
      step(); chk("r_at3", bus.state, 3);
      bus.en = 1'b0;
      step(); chk("r_dwell_pre", bus.dwell, 1);
      reset = 1'b1;
      #1;
      chk("r_async_state", bus.state, 0);
      chk("r_async_dwell", bus.dwell, 0);
      chk("r_async_prev", bus.prev_state, 0);
      #2;
      reset = 1'b0;
      bus.en = 1'b1; bus.x = 1'b1;
      step(); chk("r_ring1", bus.state, 1);
      step(); chk("r_ring2", bus.state, 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
